// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared definitions for the UART TX scheduler and TX core tests.
// Contents: FSM state encodings, the state enum built on them, and default
// gap/timeout constants for a 50 MHz system clock.
package uart_ctrl_pkg;

  localparam logic [2:0] StateIdleEnc     = 3'd0;
  localparam logic [2:0] StateLoadEnc     = 3'd1;
  localparam logic [2:0] StateWaitDoneEnc = 3'd2;
  localparam logic [2:0] StateGapEnc      = 3'd3;
  localparam logic [2:0] StateHoldEnc     = 3'd4;

  typedef enum logic [2:0] {
    StIdle     = StateIdleEnc,
    StLoad     = StateLoadEnc,
    StWaitDone = StateWaitDoneEnc,
    StGap      = StateGapEnc,
    StHold     = StateHoldEnc
  } state_e;

  // One bit time at the 16x/301 baud divider.
  localparam int unsigned DefaultGapCycles     = 4816;
  localparam int unsigned DefaultTimeoutCycles = 65535;

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester handshake plus TX core parallel-load link.
//   req_valid/req_data/req_last/req_ready : per-requester byte handshake
//   grant                                  : one-hot current owner
//   tx_data/tx_load/tx_done                : TX core data, load strobe, done level
// Modports: slave = scheduler side, master = requesters + TX core side.
interface uart_tx_sched_if #(
  parameter int unsigned NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_load;
  logic                 tx_done;

  modport slave (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, grant, tx_data, tx_load
  );

  modport master (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, grant, tx_data, tx_load
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   valid     : request vector
//   rr_ptr    : highest-priority index
//   winner    : one-hot first valid at or after rr_ptr (wrapping), 0 if none
//   any_valid : OR of valid
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PtrW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PtrW-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               any_valid
);

  always_comb begin
    logic [PtrW:0] sum;
    logic          found;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // One extra bit so ptr + i cannot overflow before the wrap.
      sum = {1'b0, rr_ptr} + (PtrW+1)'(i);
      if (sum >= (PtrW+1)'(NUM_REQ)) sum = sum - (PtrW+1)'(NUM_REQ);
      if (!found && valid[sum[PtrW-1:0]]) begin
        winner[sum[PtrW-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

  assign any_valid = |valid;

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART TX core among NUM_REQ
// byte producers, with packet locking, tx_done timeout and inter-character gap.
//   CLOCK_50    : system clock
//   reset       : asynchronous, active-high
//   bus         : requester handshake + TX core link (slave modport)
//   busy        : high in every state but idle
//   timeout_err : sticky tx_done timeout flag, cleared only by reset
module uart_tx_sched
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = DefaultGapCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  uart_tx_sched_if.slave bus,
  output logic          busy,
  output logic          timeout_err
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 lock_q, lock_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [GapW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [ToW-1:0]       to_cnt_q, to_cnt_d;
  logic                 err_q, err_d;
  logic                 tx_done_q;

  logic [NUM_REQ-1:0]   arb_winner;
  logic                 arb_any;
  logic [NUM_REQ-1:0]   pick;
  logic [PtrW-1:0]      pick_idx;
  logic [7:0]           pick_data;
  logic                 pick_last;
  logic [NUM_REQ-1:0]   ready;
  logic                 done_rise;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .valid     (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .winner    (arb_winner),
    .any_valid (arb_any)
  );

  // In HOLD only the current owner may be accepted.
  always_comb begin
    pick = '0;
    if (state_q == StIdle && arb_any) begin
      pick = arb_winner;
    end else if (state_q == StHold) begin
      pick = bus.req_valid & grant_q;
    end
    pick_idx  = '0;
    pick_data = '0;
    pick_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_idx  = PtrW'(i);
        pick_data = bus.req_data[i*8 +: 8];
        pick_last = bus.req_last[i];
      end
    end
  end

  assign done_rise = bus.tx_done & ~tx_done_q;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    lock_d    = lock_q;
    tx_data_d = tx_data_q;
    gap_cnt_d = gap_cnt_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
    ready     = '0;
    unique case (state_q)
      StIdle, StHold: begin
        if (|pick) begin
          ready     = pick;
          tx_data_d = pick_data;
          grant_d   = pick;
          owner_d   = pick_idx;
          lock_d    = ~pick_last;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        to_cnt_d = '0;
        state_d  = StWaitDone;
      end
      StWaitDone: begin
        if (done_rise) begin
          gap_cnt_d = '0;
          state_d   = StGap;
        end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          err_d     = 1'b1;
          lock_d    = 1'b0;
          gap_cnt_d = '0;
          state_d   = StGap;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          if (lock_q) begin
            state_d = StHold;
          end else begin
            state_d  = StIdle;
            grant_d  = '0;
            rr_ptr_d = (owner_q == PtrW'(NUM_REQ - 1)) ? '0 : owner_q + PtrW'(1);
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      lock_q    <= 1'b0;
      tx_data_q <= '0;
      gap_cnt_q <= '0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      lock_q    <= lock_d;
      tx_data_q <= tx_data_d;
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
      tx_done_q <= bus.tx_done;
    end
  end

  assign bus.req_ready = ready;
  assign bus.grant     = grant_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_load   = (state_q == StLoad);
  assign busy          = (state_q != StIdle);
  assign timeout_err   = err_q;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter core between NUM_REQ byte producers. Accepts bytes through per-requester valid/ready, drives the core's 8-bit parallel data and one-cycle load strobe, waits for the core's character-complete indication, then enforces an inter-character idle gap. Packets (byte runs terminated by a last flag) are never interleaved. Sits between the application logic and the TX core on the CLOCK_50 domain.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- GAP_CYCLES, 4816: CLOCK_50 cycles of forced idle after each character (one bit time at the 16x/301 divider)
- TIMEOUT_CYCLES, 65535: max CLOCK_50 cycles to wait for tx_done before abort
- CLOCK_50  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  requester i has a byte
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i]
- req_last  in  NUM_REQ  byte of requester i ends its packet
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
- grant  out  NUM_REQ  one-hot current owner, 0 when idle
- tx_data  out  8  byte presented to the TX core
- tx_load  out  1  one-cycle parallel-load strobe to the TX core
- tx_done  in  1  TX core character-complete level
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; set on tx_done timeout, cleared only by reset

## Operation
- States: IDLE, LOAD, WAIT_DONE, GAP, HOLD.
- IDLE: if any req_valid, winner = first valid requester at or after rr_ptr (wrapping). Same cycle: req_ready[winner]=1, latch req_data into tx_data, grant=winner one-hot, lock = ~req_last[winner]; next state LOAD. No valid: stay.
- LOAD: tx_load=1 for exactly this cycle; clear timeout counter; -> WAIT_DONE.
- WAIT_DONE: advance on rising edge of tx_done only (tx_done_q registered, reset 0); a level already high on entry is ignored. On edge -> GAP. If timeout counter reaches TIMEOUT_CYCLES-1: set timeout_err, clear lock, -> GAP.
- GAP: count GAP_CYCLES; at terminal count, lock=1 -> HOLD, lock=0 -> IDLE with rr_ptr = winner+1 mod NUM_REQ and grant=0.
- HOLD: only the owner is considered; other valids ignored. Owner valid: accept exactly as in IDLE (req_ready pulse, latch data, lock = ~req_last) -> LOAD.
- At most one req_ready bit high per cycle; never asserted outside IDLE/HOLD.
- tx_data holds its value from accept until the next accept.

## Timing
- Reset (any state, mid-character included): state IDLE, rr_ptr 0, lock 0, req_ready 0, grant 0, tx_data 0x00, tx_load 0, busy 0, timeout_err 0, counters 0. Core is not notified; its own reset is shared.
- Accept at cycle N -> tx_load high at N+1 -> earliest next accept at tx_done edge + GAP_CYCLES + 1.
- Simultaneous valids: rr order from rr_ptr; after reset requester 0 wins ties.
- Requester dropping valid after acceptance has no effect; valid without ready must hold data (not checked).
- Owner idle in HOLD: wait indefinitely (no timeout in HOLD).
- tx_done rising in LOAD cycle: ignored (edge detect only armed in WAIT_DONE).

## Structure
- Package uart_ctrl_pkg: state encoding localparams (IDLE..HOLD), default GAP_CYCLES/TIMEOUT_CYCLES constants, shared with TX core tests.
- One sub-module: rr_arbiter (combinational, inputs valid vector and rr_ptr, outputs one-hot winner and any_valid).
- Counters: gap and timeout counters sized by $clog2 of their parameters.

## Test plan
- Single byte: req_valid[2]=1, data 0x41, last=1 -> req_ready[2] pulse, tx_load next cycle with tx_data 0x41; tx_done edge -> busy low after GAP_CYCLES+1.
- Contention: valid on 0,1,3 with last=1 each -> service order 0,1,3, then 0 again on reassert; rr_ptr wraps.
- Packet lock: requester 1 sends 0x10 (last=0), 0x11 (last=1) while requester 0 valid -> both bytes of 1 sent before 0 is granted.
- Timeout: tx_done held 0 after load -> timeout_err=1 at TIMEOUT_CYCLES, lock cleared, next requester served; err stays 1.
- Stale level: tx_done already 1 at LOAD, drops, rises later -> transition to GAP only on the later rise.
- Reset mid-WAIT_DONE: all outputs return to reset values immediately; next request after reset goes to requester 0.
